serializador_paralelo: RTL and testbench

Parallel-in, serial-out shift register with a load/ready handshake on the parallel side and a valid/last-qualified bit stream on the serial side. It is the transmit-side counterpart of the parallel register: it takes a word captured in parallel and emits it one bit per clock, MSB first. An optional even-parity bit can be appended to each frame.

---
 rtl/serializador_pkg.sv | 13 +
 rtl/serializador_paralelo_contador_bits.sv | 33 +++
 rtl/serializador_paralelo.sv | 134 +++++++++++++
 tb/tb_serializador_paralelo.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serializador_pkg.sv
// Shared definitions for the parallel-to-serial transmitter:
// FSM state encoding and the default word width.
package serializador_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } estado_t;

    localparam int BITS_PADRAO = 8;

endpackage

// File: rtl/serializador_paralelo_contador_bits.sv
// contador_bits: up-counter with synchronous clear and a terminal-count flag.
// Counts 0..MAX and holds at MAX; it never wraps on its own.
module contador_bits #(
    parameter int WIDTH = 3,
    parameter int MAX   = 7
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             terminal
);

    localparam logic [WIDTH-1:0] ULTIMO = WIDTH'(MAX);

    logic [WIDTH-1:0] count_reg;

    // Clear has priority over increment; increment stops at the terminal value.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != ULTIMO)) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count    = count_reg;
    assign terminal = (count_reg == ULTIMO);

endmodule

// File: rtl/serializador_paralelo.sv
// serializador_paralelo: parallel-in, serial-out shifter, MSB first.
// A word is captured when load && ready; one bit is presented per clock with
// serial_valid, and last flags the final bit of the frame.
// Optional even-parity bit after the LSB: define SERIALIZADOR_PARITY_EN.
module serializador_paralelo
    import serializador_pkg::*;
#(
    parameter int BITS = BITS_PADRAO
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] in,
    input  logic            load,
    output logic            ready,
    output logic            serial_out,
    output logic            serial_valid,
    output logic            last
);

    localparam int CW = $clog2(BITS);
`ifndef SERIALIZADOR_PARITY_EN
    localparam logic [CW-1:0] PENULTIMO = CW'(BITS - 2);
`endif

    estado_t         estado_reg;
    // Holds the bits not yet presented; the MSB goes straight to serial_out.
    logic [BITS-2:0] shreg_reg;
    logic            serial_out_reg;
    logic            serial_valid_reg;
    logic            last_reg;
    logic            ready_reg;
`ifdef SERIALIZADOR_PARITY_EN
    logic            parity_reg;
`endif

    logic [CW-1:0]   indice;
    logic            indice_fim;
    logic            aceita;
    logic            avanca;

    assign aceita = load && ready_reg && (estado_reg == IDLE);
    assign avanca = (estado_reg == SHIFT) && !indice_fim;

    // Index of the data bit currently on serial_out.
    contador_bits #(
        .WIDTH (CW),
        .MAX   (BITS - 1)
    ) u_contador (
        .clk      (clk),
        .srst     (rst),
        .clr      (aceita),
        .en       (avanca),
        .count    (indice),
        .terminal (indice_fim)
    );

    // Frame FSM: capture, shift out MSB first, optional parity bit, back to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_reg       <= IDLE;
            shreg_reg        <= '0;
            serial_out_reg   <= 1'b0;
            serial_valid_reg <= 1'b0;
            last_reg         <= 1'b0;
            ready_reg        <= 1'b1;
`ifdef SERIALIZADOR_PARITY_EN
            parity_reg       <= 1'b0;
`endif
        end else begin
            case (estado_reg)
                IDLE: begin
                    if (aceita) begin
                        estado_reg       <= SHIFT;
                        shreg_reg        <= in[BITS-2:0];
                        serial_out_reg   <= in[BITS-1];
                        serial_valid_reg <= 1'b1;
                        last_reg         <= 1'b0;
                        ready_reg        <= 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
                        parity_reg       <= in[BITS-1];
`endif
                    end
                end
                SHIFT: begin
                    if (!indice_fim) begin
                        shreg_reg      <= shreg_reg << 1;
                        serial_out_reg <= shreg_reg[BITS-2];
`ifdef SERIALIZADOR_PARITY_EN
                        parity_reg     <= parity_reg ^ shreg_reg[BITS-2];
                        last_reg       <= 1'b0;
`else
                        last_reg       <= (indice == PENULTIMO);
`endif
                    end else begin
`ifdef SERIALIZADOR_PARITY_EN
                        // LSB just went out: parity_reg now holds XOR of the word.
                        estado_reg       <= PARITY;
                        serial_out_reg   <= parity_reg;
                        last_reg         <= 1'b1;
`else
                        estado_reg       <= IDLE;
                        serial_out_reg   <= 1'b0;
                        serial_valid_reg <= 1'b0;
                        last_reg         <= 1'b0;
                        ready_reg        <= 1'b1;
`endif
                    end
                end
`ifdef SERIALIZADOR_PARITY_EN
                PARITY: begin
                    estado_reg       <= IDLE;
                    serial_out_reg   <= 1'b0;
                    serial_valid_reg <= 1'b0;
                    last_reg         <= 1'b0;
                    ready_reg        <= 1'b1;
                end
`endif
                default: begin
                    estado_reg       <= IDLE;
                    serial_out_reg   <= 1'b0;
                    serial_valid_reg <= 1'b0;
                    last_reg         <= 1'b0;
                    ready_reg        <= 1'b1;
                end
            endcase
        end
    end

    assign ready        = ready_reg;
    assign serial_out   = serial_out_reg;
    assign serial_valid = serial_valid_reg;
    assign last         = last_reg;

endmodule

// File: tb/tb_serializador_paralelo.sv
// Self-checking bench for serializador_paralelo (BITS = 8).
// A frame-position model predicts every output each cycle; directed frames
// from the test plan add literal checks. Honours SERIALIZADOR_PARITY_EN.
module tb_serializador_paralelo;

    localparam int BITS = 8;
`ifdef SERIALIZADOR_PARITY_EN
    localparam int FRAME = BITS + 1;
`else
    localparam int FRAME = BITS;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [BITS-1:0] in = '0;
    logic            load = 1'b0;
    logic            ready;
    logic            serial_out;
    logic            serial_valid;
    logic            last;

    int vectors = 0;
    int miscompares = 0;

    serializador_paralelo #(.BITS(BITS)) dut (
        .clk          (clk),
        .rst          (rst),
        .in           (in),
        .load         (load),
        .ready        (ready),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .last         (last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, exp);
        end
    endtask

    // Bit i of a frame carrying word w: data MSB first, then the parity bit.
    function automatic logic frame_bit(input logic [BITS-1:0] w, input int i);
        if (i < BITS) return w[BITS-1-i];
        return ^w;
    endfunction

    // Reference model: position within the current frame (-1 = idle).
    int              m_pos  = -1;
    logic [BITS-1:0] m_word = '0;
    bit              m_init = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_pos  = -1;
            m_init = 1'b1;
        end else if (m_init) begin
            if (m_pos < 0) begin
                if (load) begin
                    m_pos  = 0;
                    m_word = in;
                end
            end else if (m_pos == FRAME - 1) begin
                m_pos = -1;
            end else begin
                m_pos = m_pos + 1;
            end
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        if (m_init) begin
            chk("model_valid", serial_valid, m_pos >= 0);
            chk("model_ready", ready, m_pos < 0);
            chk("model_last",  last, m_pos == FRAME - 1);
            chk("model_out",   serial_out, (m_pos >= 0) ? frame_bit(m_word, m_pos) : 1'b0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Single frame: load for one cycle, check every bit, last and ready return.
    task automatic run_frame(input logic [BITS-1:0] w);
        in = w;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            chk("frm_out",   serial_out, frame_bit(w, i));
            chk("frm_last",  last, i == FRAME - 1);
            chk("frm_valid", serial_valid, 1'b1);
            chk("frm_ready", ready, 1'b0);
            tick();
        end
        chk("frm_ready_back", ready, 1'b1);
        chk("frm_valid_end",  serial_valid, 1'b0);
        chk("frm_out_zero",   serial_out, 1'b0);
    endtask

    initial begin
        logic [7:0] pat;

        // Reset state.
        tick();
        tick();
        chk("rst_ready", ready, 1'b1);
        chk("rst_valid", serial_valid, 1'b0);
        chk("rst_out",   serial_out, 1'b0);
        chk("rst_last",  last, 1'b0);
        rst = 1'b0;

        // 0x55: literal bit pattern 0,1,0,1,...
        pat = 8'b0101_0101;
        in = pat;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < BITS; i++) begin
            chk("p55_out",  serial_out, (i % 2) == 1);
            chk("p55_last", last, (FRAME == BITS) && (i == BITS - 1));
            tick();
        end
`ifdef SERIALIZADOR_PARITY_EN
        chk("p55_par",  serial_out, 1'b0);
        chk("p55_plst", last, 1'b1);
        tick();
`endif
        chk("p55_ready", ready, 1'b1);

        // Held load, input changes mid-frame; second frame at first ready edge.
        in = 8'hAA;
        load = 1'b1;
        tick();
        for (int i = 0; i < FRAME; i++) begin
            chk("hold1_out", serial_out, frame_bit(8'hAA, i));
            if (i == 3) in = 8'hFF;
            tick();
        end
        chk("hold_gap_valid", serial_valid, 1'b0);
        chk("hold_gap_ready", ready, 1'b1);
        tick();
        for (int i = 0; i < FRAME; i++) begin
            chk("hold2_valid", serial_valid, 1'b1);
            chk("hold2_out", serial_out, (i < BITS) ? 1'b1 : 1'b0);
            load = 1'b0;
            tick();
        end
        chk("hold2_end", serial_valid, 1'b0);

        // Load pulse during a frame is ignored.
        in = 8'hA5;
        load = 1'b1;
        tick();
        load = 1'b0;
        pat = 8'hA5;
        for (int i = 0; i < FRAME; i++) begin
            chk("pulse_out", serial_out, frame_bit(pat, i));
            if (i == 2) begin
                load = 1'b1;
                in = 8'h3C;
            end else begin
                load = 1'b0;
            end
            tick();
        end
        chk("pulse_idle1", serial_valid, 1'b0);
        tick();
        chk("pulse_idle2", serial_valid, 1'b0);
        chk("pulse_ready", ready, 1'b1);

        // Reset during the 4th bit of 0xF0 aborts the frame.
        in = 8'hF0;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("abort_out", serial_out, i < 4);
            if (i == 3) rst = 1'b1;
            tick();
        end
        chk("abort_valid", serial_valid, 1'b0);
        chk("abort_out0",  serial_out, 1'b0);
        chk("abort_last",  last, 1'b0);
        chk("abort_ready", ready, 1'b1);
        rst = 1'b0;
        run_frame(8'h0F);

        // Load and reset together: no frame.
        in = 8'hFF;
        load = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load = 1'b0;
        chk("rl_ready", ready, 1'b1);
        chk("rl_valid", serial_valid, 1'b0);
        tick();
        chk("rl_valid2", serial_valid, 1'b0);

`ifdef SERIALIZADOR_PARITY_EN
        // Parity literals: 0x07 -> 1, 0x03 -> 0, ready back at k+10.
        in = 8'h07;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < BITS; i++) tick();
        chk("par07_bit",   serial_out, 1'b1);
        chk("par07_last",  last, 1'b1);
        chk("par07_valid", serial_valid, 1'b1);
        tick();
        chk("par07_ready", ready, 1'b1);
        in = 8'h03;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < BITS; i++) tick();
        chk("par03_bit",  serial_out, 1'b0);
        chk("par03_last", last, 1'b1);
        tick();
`endif

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 99) < 2);
            load = ($urandom_range(0, 99) < 35);
            in   = BITS'($urandom);
            tick();
        end
        rst = 1'b0;
        load = 1'b0;
        for (int c = 0; c < FRAME + 2; c++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
